// File: rtl/gnrl_iq_comb_decimator_pkg.sv
// Shared definitions for the I/Q accumulate-and-dump decimator:
// default widths, the minimum decimation factor and the output sequencer states.
package gnrl_iq_comb_decimator_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEC_WIDTH_DEF  = 16;
  localparam int MIN_DEC_FACT   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_I = 2'd1,
    SEND_Q = 2'd2
  } seq_state_t;

endpackage

// File: rtl/gnrl_iq_accum.sv
// One channel of the decimator: wrapping accumulator plus a holding register
// that captures the completed block sum on the dump strobe.
module gnrl_iq_accum #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  accept,
  input  logic                  dump,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [DATA_WIDTH-1:0] hold
);

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_sum;

  // Modulo 2^DATA_WIDTH arithmetic: no growth or saturation.
  assign acc_sum = acc + sample;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc  <= '0;
      hold <= '0;
    end else if (accept) begin
      if (dump) begin
        hold <= acc_sum;
        acc  <= '0;
      end else begin
        acc <= acc_sum;
      end
    end
  end

endmodule

// File: rtl/gnrl_iq_comb_decimator.sv
// Accumulate-and-dump I/Q decimator: sums Neff accepted samples per channel and
// serialises the I sum then the Q sum onto a single output bus.
module gnrl_iq_comb_decimator
  import gnrl_iq_comb_decimator_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEC_WIDTH  = DEC_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] dataI,
  input  logic [DATA_WIDTH-1:0] dataQ,
  input  logic                  in_valid,
  input  logic [DEC_WIDTH-1:0]  dec_fact,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  out_valid
);

  logic [DEC_WIDTH-1:0]  cnt;
  logic [DEC_WIDTH-1:0]  neff_q;
  logic [DEC_WIDTH-1:0]  neff_start;
  logic [DEC_WIDTH-1:0]  neff_now;
  logic                  accept;
  logic                  dump;
  logic [DATA_WIDTH-1:0] hold_i;
  logic [DATA_WIDTH-1:0] hold_q;
  seq_state_t            state;

  assign accept = in_valid;

  // The first sample of a block sees the live factor; later samples use the latch.
  always_comb begin
    neff_start = dec_fact;
    if (dec_fact < DEC_WIDTH'(MIN_DEC_FACT)) begin
      neff_start = DEC_WIDTH'(MIN_DEC_FACT);
    end
    neff_now = (cnt == '0) ? neff_start : neff_q;
    dump     = accept && (cnt == (neff_now - DEC_WIDTH'(1)));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt    <= '0;
      neff_q <= '0;
    end else if (accept) begin
      if (cnt == '0) begin
        neff_q <= neff_start;
      end
      cnt <= dump ? '0 : cnt + DEC_WIDTH'(1);
    end
  end

  gnrl_iq_accum #(.DATA_WIDTH(DATA_WIDTH)) u_accum_i (
    .CLK    (CLK),
    .RESET  (RESET),
    .accept (accept),
    .dump   (dump),
    .sample (dataI),
    .hold   (hold_i)
  );

  gnrl_iq_accum #(.DATA_WIDTH(DATA_WIDTH)) u_accum_q (
    .CLK    (CLK),
    .RESET  (RESET),
    .accept (accept),
    .dump   (dump),
    .sample (dataQ),
    .hold   (hold_q)
  );

  // SEND_Q can chain straight into SEND_I when Neff = 2 keeps the stream full.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= dump ? SEND_I : IDLE;
        SEND_I:  state <= SEND_Q;
        SEND_Q:  state <= dump ? SEND_I : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // In IDLE the bus shows hold_q, which is the last word sent (0 after reset).
  assign out_valid = (state != IDLE);
  assign dataout   = (state == SEND_I) ? hold_i : hold_q;

endmodule

// File: tb/tb_gnrl_iq_comb_decimator.sv
// Randomised scoreboard bench for the I/Q decimator: a block-sum reference model
// queues expected words with their due cycle; a monitor compares every cycle.
module tb_gnrl_iq_comb_decimator;
  import gnrl_iq_comb_decimator_pkg::*;

  localparam int DW = 32;
  localparam int KW = 16;

  // clock / reset
  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] dataI = '0;
  logic [DW-1:0] dataQ = '0;
  logic [KW-1:0] dec_fact = KW'(3);
  logic [DW-1:0] dataout;
  logic          out_valid;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  gnrl_iq_comb_decimator #(.DATA_WIDTH(DW), .DEC_WIDTH(KW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .dataI     (dataI),
    .dataQ     (dataQ),
    .in_valid  (in_valid),
    .dec_fact  (dec_fact),
    .dataout   (dataout),
    .out_valid (out_valid)
  );

  // scoreboard state
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  int            cyc_q[$];
  int            ov_count = 0;

  // reference model: current block contents
  int            blk_cnt = 0;
  int            blk_n = 0;
  logic [DW-1:0] sum_i = '0;
  logic [DW-1:0] sum_q = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Drives one clock's inputs (applied at the next edge) and updates the model.
  task automatic drive(input bit rst, input bit v, input logic [DW-1:0] i,
                       input logic [DW-1:0] q, input int d);
    @(posedge CLK);
    #1;
    RESET    = rst;
    in_valid = v;
    dataI    = i;
    dataQ    = q;
    dec_fact = KW'(d);
    if (rst) begin
      // words due after the reset edge are never sent
      while (cyc_q.size() > 0 && cyc_q[$] > cyc) begin
        void'(cyc_q.pop_back());
        void'(exp_q.pop_back());
      end
      blk_cnt = 0;
      sum_i   = '0;
      sum_q   = '0;
    end else if (v) begin
      if (blk_cnt == 0) blk_n = (d < 2) ? 2 : d;
      sum_i = sum_i + i;
      sum_q = sum_q + q;
      blk_cnt++;
      if (blk_cnt == blk_n) begin
        exp_q.push_back(sum_i);
        cyc_q.push_back(cyc + 1);
        exp_q.push_back(sum_q);
        cyc_q.push_back(cyc + 2);
        blk_cnt = 0;
        sum_i   = '0;
        sum_q   = '0;
      end
    end
  endtask

  task automatic idle(input int n, input int d);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0, '0, d);
  endtask

  // monitor
  logic          rst_d = 1'b1;
  logic [DW-1:0] last_out = '0;
  always @(posedge CLK) rst_d <= RESET;

  always @(negedge CLK) begin
    logic          ev;
    logic [DW-1:0] e;
    ev = (cyc_q.size() > 0) && (cyc_q[0] == cyc);
    if (rst_d) begin
      check("reset_valid", DW'(out_valid), '0);
      check("reset_data", dataout, '0);
      last_out = '0;
    end else begin
      check("out_valid", DW'(out_valid), DW'(ev));
      if (ev) begin
        e = exp_q.pop_front();
        void'(cyc_q.pop_front());
        check("dataout", dataout, e);
        last_out = e;
      end else begin
        check("hold_value", dataout, last_out);
      end
      if (out_valid) ov_count++;
    end
  end

  initial begin
    int ov0;
    repeat (3) drive(1'b1, 1'b0, '0, '0, 3);

    // basic block: expect 6 then 60
    drive(1'b0, 1'b1, 1, 10, 3);
    drive(1'b0, 1'b1, 2, 20, 3);
    drive(1'b0, 1'b1, 3, 30, 3);
    idle(4, 3);

    // continuous random stream, Neff = 3
    ov0 = ov_count;
    for (int k = 0; k < 400; k++)
      drive(1'b0, 1'b1, DW'($urandom_range(0, 7999)), DW'($urandom_range(0, 7999)), 3);
    idle(5, 3);
    check("t2_valid_cycles", DW'(ov_count - ov0), DW'(266));

    // gap in the middle of a block
    drive(1'b0, 1'b1, 5, 1, 4);
    drive(1'b0, 1'b1, 5, 1, 4);
    idle(100, 4);
    drive(1'b0, 1'b1, 5, 1, 4);
    drive(1'b0, 1'b1, 5, 1, 4);
    idle(4, 4);

    // minimum factor clamp
    for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, 1, 2, 0);
    for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, 1, 2, 1);
    idle(4, 2);

    // wrap, then factor change after the first sample of a block
    drive(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 2);
    drive(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 2);
    drive(1'b0, 1'b1, 7, 3, 2);
    drive(1'b0, 1'b1, 9, 4, 5);
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, DW'($urandom), DW'($urandom), 5);
    idle(4, 5);

    // reset mid-block (with a sample on the reset edge), then during the output pair
    drive(1'b0, 1'b1, 100, 100, 3);
    drive(1'b0, 1'b1, 100, 100, 3);
    drive(1'b1, 1'b1, 99, 99, 3);
    drive(1'b0, 1'b1, 1, 2, 3);
    drive(1'b0, 1'b1, 1, 2, 3);
    drive(1'b0, 1'b1, 1, 2, 3);
    drive(1'b0, 1'b0, 0, 0, 3);
    drive(1'b1, 1'b0, 0, 0, 3);
    idle(2, 3);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, DW'($urandom_range(0, 50)), DW'($urandom_range(0, 50)), 3);
    idle(5, 3);

    check("queue_drained", DW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
